// File: rtl/quad_encoder_emulator_if.sv
// Stimulus/status bundle for the quadrature encoder emulator.
// The bench or a controller uses master; the emulator uses slave.
interface quad_encoder_emulator_if #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 16
);
    logic                i_start;
    logic                i_dir;
    logic [PERIOD_W-1:0] i_period;
    logic [COUNT_W-1:0]  i_steps;
    logic                i_stop;
    logic                o_A;
    logic                o_B;
    logic                o_Z;
    logic                o_busy;
    logic                o_done;
    logic [COUNT_W-1:0]  o_position;

    modport master (
        output i_start, i_dir, i_period, i_steps, i_stop,
        input  o_A, o_B, o_Z, o_busy, o_done, o_position
    );

    modport slave (
        input  i_start, i_dir, i_period, i_steps, i_stop,
        output o_A, o_B, o_Z, o_busy, o_done, o_position
    );
endinterface

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder signal source: emits A/B edges at a programmable period,
// finite or continuous, in either direction, tracking signed position and index.
module quad_encoder_emulator #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 16,
    parameter int CPR      = 1024
) (
    input logic Clk,
    input logic Reset,
    quad_encoder_emulator_if.slave bus
);
    localparam int REV_W = (CPR > 1) ? $clog2(CPR) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                dir_q, dir_d;
    logic                continuous_q, continuous_d;
    logic [COUNT_W-1:0]  remaining_q, remaining_d;
    logic                a_q, a_d;
    logic                b_q, b_d;
    logic                z_q, z_d;
    logic                done_q, done_d;
    logic [COUNT_W-1:0]  position_q, position_d;
    logic [REV_W-1:0]    rev_q, rev_d;
    logic                step;

    // Gray-code walk of {A,B}; forward has A leading B.
    function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic rev);
        logic [1:0] nxt;
        nxt = 2'b00;
        if (!rev) begin
            case (ab)
                2'b00:   nxt = 2'b10;
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end else begin
            case (ab)
                2'b00:   nxt = 2'b01;
                2'b01:   nxt = 2'b11;
                2'b11:   nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        period_d     = period_q;
        dir_d        = dir_q;
        continuous_d = continuous_q;
        remaining_d  = remaining_q;
        a_d          = a_q;
        b_d          = b_q;
        z_d          = z_q;
        position_d   = position_q;
        rev_d        = rev_q;
        done_d       = 1'b0;
        step         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    dir_d        = bus.i_dir;
                    period_d     = (bus.i_period == '0) ? PERIOD_W'(1) : bus.i_period;
                    continuous_d = (bus.i_steps == '0);
                    remaining_d  = bus.i_steps;
                    timer_d      = PERIOD_W'(1);
                    state_d      = RUN;
                end
            end
            RUN: begin
                // A stop coinciding with the period boundary suppresses that edge.
                if (bus.i_stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (timer_q == period_q) begin
                    step    = 1'b1;
                    timer_d = PERIOD_W'(1);
                    if (!continuous_q) begin
                        remaining_d = remaining_q - COUNT_W'(1);
                        if (remaining_q == COUNT_W'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    timer_d = timer_q + PERIOD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (step) begin
            {a_d, b_d} = next_phase({a_q, b_q}, dir_q);
            if (!dir_q) begin
                position_d = position_q + COUNT_W'(1);
                rev_d      = (rev_q == REV_W'(CPR - 1)) ? '0 : rev_q + REV_W'(1);
            end else begin
                position_d = position_q - COUNT_W'(1);
                rev_d      = (rev_q == '0) ? REV_W'(CPR - 1) : rev_q - REV_W'(1);
            end
            z_d = (rev_d == '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            timer_q      <= PERIOD_W'(1);
            period_q     <= PERIOD_W'(1);
            dir_q        <= 1'b0;
            continuous_q <= 1'b0;
            remaining_q  <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            z_q          <= 1'b0;
            done_q       <= 1'b0;
            position_q   <= '0;
            rev_q        <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            period_q     <= period_d;
            dir_q        <= dir_d;
            continuous_q <= continuous_d;
            remaining_q  <= remaining_d;
            a_q          <= a_d;
            b_q          <= b_d;
            z_q          <= z_d;
            done_q       <= done_d;
            position_q   <= position_d;
            rev_q        <= rev_d;
        end
    end

    assign bus.o_A        = a_q;
    assign bus.o_B        = b_q;
    assign bus.o_Z        = z_q;
    assign bus.o_busy     = (state_q == RUN);
    assign bus.o_done     = done_q;
    assign bus.o_position = position_q;
endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator (CPR=8): table of finite runs plus
// cycle-exact sequences for timing, index, stop, restart and mid-run reset.
module tb_quad_encoder_emulator;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    quad_encoder_emulator_if #(.PERIOD_W(16), .COUNT_W(16)) bus ();

    quad_encoder_emulator #(.PERIOD_W(16), .COUNT_W(16), .CPR(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        dir;
        logic [15:0] period;
        logic [15:0] steps;
        logic [1:0]  ab;
        logic [15:0] pos;
        int          busy;
        logic        z;
        logic        z_ever;
    } vec_t;

    vec_t       vecs [5];
    logic [1:0] fwd_tab [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Leaves the caller just after the start-sampling edge (cycle offset 0).
    task automatic start(input logic dir, input logic [15:0] period, input logic [15:0] steps,
                         input logic stop);
        bus.i_dir    = dir;
        bus.i_period = period;
        bus.i_steps  = steps;
        bus.i_start  = 1'b1;
        bus.i_stop   = stop;
        tick();
        bus.i_start  = 1'b0;
        bus.i_stop   = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         busy_cnt;
        int         edges;
        logic       z_ever;
        logic       got_done;
        logic [1:0] prev;
        logic [1:0] ab;
        busy_cnt = 0;
        edges    = 0;
        z_ever   = 1'b0;
        got_done = 1'b0;
        prev     = {bus.o_A, bus.o_B};
        start(v.dir, v.period, v.steps, 1'b0);
        for (int c = 0; c < 5000; c++) begin
            ab = {bus.o_A, bus.o_B};
            if (ab != prev) begin
                edges++;
                prev = ab;
                if (bus.o_Z) z_ever = 1'b1;
            end
            if (bus.o_done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.o_busy) busy_cnt++;
            tick();
        end
        chk($sformatf("vec%0d_done_seen", idx), 32'(got_done), 32'd1);
        chk($sformatf("vec%0d_busy_cycles", idx), busy_cnt, v.busy);
        chk($sformatf("vec%0d_edges", idx), edges, 32'(v.steps));
        chk($sformatf("vec%0d_ab", idx), {bus.o_A, bus.o_B}, v.ab);
        chk($sformatf("vec%0d_position", idx), bus.o_position, v.pos);
        chk($sformatf("vec%0d_z", idx), bus.o_Z, v.z);
        chk($sformatf("vec%0d_z_ever", idx), z_ever, v.z_ever);
        tick();
        chk($sformatf("vec%0d_done_one_cycle", idx), bus.o_done, 1'b0);
    endtask

    initial begin
        int edges;
        vec_t rec;

        fwd_tab[0] = 2'b00;
        fwd_tab[1] = 2'b10;
        fwd_tab[2] = 2'b11;
        fwd_tab[3] = 2'b01;
        //          dir  period  steps   ab     pos       busy z     z_ever
        vecs[0] = '{1'b1, 16'd2, 16'd4, 2'b00, 16'hFFFC, 8,  1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'd0, 16'd3, 2'b01, 16'hFFFF, 3,  1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'd1, 16'd3, 2'b11, 16'h0002, 3,  1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'd4, 16'd2, 2'b00, 16'h0000, 8,  1'b1, 1'b1};
        vecs[4] = '{1'b0, 16'd2, 16'd5, 2'b10, 16'h0005, 10, 1'b0, 1'b0};

        bus.i_start  = 1'b0;
        bus.i_dir    = 1'b0;
        bus.i_period = '0;
        bus.i_steps  = '0;
        bus.i_stop   = 1'b0;
        #1;
        do_reset();

        chk("rst_A", bus.o_A, 1'b0);
        chk("rst_B", bus.o_B, 1'b0);
        chk("rst_Z", bus.o_Z, 1'b0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_done", bus.o_done, 1'b0);
        chk("rst_position", bus.o_position, 16'h0);

        // Forward, period 3, 4 steps: edges at k+3,6,9,12, busy k..k+11, done at k+12.
        start(1'b0, 16'd3, 16'd4, 1'b0);
        chk("fwd_busy_c0", bus.o_busy, 1'b1);
        for (int c = 1; c <= 13; c++) begin
            tick();
            edges = (c / 3 > 4) ? 4 : c / 3;
            chk($sformatf("fwd_ab_c%0d", c), {bus.o_A, bus.o_B}, fwd_tab[edges % 4]);
            chk($sformatf("fwd_busy_c%0d", c), bus.o_busy, (c <= 11) ? 1'b1 : 1'b0);
            chk($sformatf("fwd_done_c%0d", c), bus.o_done, (c == 12) ? 1'b1 : 1'b0);
        end
        chk("fwd_position", bus.o_position, 16'd4);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            rec = vecs[i];
            run_vec(i, rec);
        end

        // Index: CPR=8, 16 forward edges, one per cycle.
        do_reset();
        start(1'b0, 16'd1, 16'd16, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk($sformatf("idx_z_c%0d", c), bus.o_Z, (c % 8 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("idx_pos_c%0d", c), bus.o_position, 16'(c));
        end
        chk("idx_done", bus.o_done, 1'b1);
        tick();

        // Stop in IDLE is ignored.
        bus.i_stop = 1'b1;
        tick();
        bus.i_stop = 1'b0;
        chk("idle_stop_busy", bus.o_busy, 1'b0);
        chk("idle_stop_done", bus.o_done, 1'b0);
        chk("idle_stop_pos", bus.o_position, 16'd16);

        // Continuous, period 5; restart attempt at c7 ignored; stop hits the 3rd boundary.
        start(1'b0, 16'd5, 16'd0, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            tick();
            edges = (c >= 10) ? 2 : c / 5;
            chk($sformatf("cont_ab_c%0d", c), {bus.o_A, bus.o_B}, fwd_tab[edges % 4]);
            chk($sformatf("cont_busy_c%0d", c), bus.o_busy, (c < 15) ? 1'b1 : 1'b0);
            chk($sformatf("cont_done_c%0d", c), bus.o_done, (c == 15) ? 1'b1 : 1'b0);
            bus.i_start = (c == 7);
            bus.i_dir   = (c == 7);
            bus.i_stop  = (c == 14);
        end
        chk("cont_position", bus.o_position, 16'd18);

        // New start accepted on the done cycle.
        start(1'b1, 16'd1, 16'd1, 1'b0);
        chk("restart_busy", bus.o_busy, 1'b1);
        chk("restart_done_low", bus.o_done, 1'b0);
        chk("restart_ab_hold", {bus.o_A, bus.o_B}, 2'b11);
        tick();
        chk("restart_ab", {bus.o_A, bus.o_B}, 2'b10);
        chk("restart_done", bus.o_done, 1'b1);
        chk("restart_pos", bus.o_position, 16'd17);
        tick();

        // Start with stop in IDLE proceeds; reset after 2 edges clears everything.
        start(1'b0, 16'd2, 16'd10, 1'b1);
        for (int c = 1; c <= 4; c++) tick();
        chk("mid_busy", bus.o_busy, 1'b1);
        chk("mid_ab", {bus.o_A, bus.o_B}, 2'b01);
        chk("mid_pos", bus.o_position, 16'd19);
        Reset = 1'b1;
        tick();
        chk("mid_rst_ab", {bus.o_A, bus.o_B}, 2'b00);
        chk("mid_rst_pos", bus.o_position, 16'd0);
        chk("mid_rst_busy", bus.o_busy, 1'b0);
        chk("mid_rst_done", bus.o_done, 1'b0);
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mid_post_done_c%0d", c), bus.o_done, 1'b0);
            chk($sformatf("mid_post_busy_c%0d", c), bus.o_busy, 1'b0);
        end
        rec = '{1'b0, 16'd1, 16'd2, 2'b11, 16'h0002, 2, 1'b0, 1'b0};
        run_vec(5, rec);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
